// File: rtl/sc_pkg.sv
// Shared types and defaults for the stochastic-to-binary conversion scheduler.
package sc_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, SCALE, DONE} sc_sched_state_t;

  localparam int SC_STREAM_LEN = 16;
  localparam int SC_MAX_W      = 8;

  // Ceiling log2; exact for the power-of-two stream lengths used here.
  function automatic int sc_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_count_scale.sv
// Shared datapath: latches one stochastic word, counts its ones bit-serially,
// then scales the count by the latched full-scale value.
module sc_count_scale
  import sc_pkg::*;
#(
  parameter  int STREAM_LEN = SC_STREAM_LEN,
  parameter  int MAX_W      = SC_MAX_W,
  localparam int CNT_W      = $clog2(STREAM_LEN + 1),
  localparam int IDX_W      = sc_log2(STREAM_LEN),
  localparam int PROD_W     = CNT_W + MAX_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  step_i,
  input  logic                  scale_i,
  input  logic [STREAM_LEN-1:0] stream_i,
  input  logic [MAX_W-1:0]      maxnum_i,
  output logic                  last_bit_o,
  output logic [MAX_W-1:0]      result_o
);

  logic [STREAM_LEN-1:0] stream_q, stream_d;
  logic [MAX_W-1:0]      maxnum_q, maxnum_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      ones_q, ones_d;
  logic [MAX_W-1:0]      result_q, result_d;
  logic [PROD_W-1:0]     product;

  // ones never exceeds STREAM_LEN, so the shifted product always fits MAX_W.
  assign product = PROD_W'(ones_q) * PROD_W'(maxnum_q);

  always_comb begin
    stream_d = stream_q;
    maxnum_d = maxnum_q;
    idx_d    = idx_q;
    ones_d   = ones_q;
    result_d = result_q;
    if (start_i) begin
      stream_d = stream_i;
      maxnum_d = maxnum_i;
      idx_d    = '0;
      ones_d   = '0;
    end else if (step_i) begin
      ones_d = ones_q + CNT_W'(stream_q[idx_q]);
      idx_d  = idx_q + IDX_W'(1);
    end
    if (scale_i) result_d = MAX_W'(product >> IDX_W);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stream_q <= '0;
      maxnum_q <= '0;
      idx_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      stream_q <= stream_d;
      maxnum_q <= maxnum_d;
      idx_q    <= idx_d;
      ones_q   <= ones_d;
      result_q <= result_d;
    end
  end

  assign last_bit_o = (idx_q == IDX_W'(STREAM_LEN - 1));
  assign result_o   = result_q;

endmodule

// File: rtl/sc_convert_sched.sv
// Round-robin scheduler sharing one count-and-scale engine between requesters.
//   state | meaning
//   IDLE  | waiting for a request; grants the next requester after the last one
//   COUNT | one stream bit accumulated per cycle
//   SCALE | ones * maxnum >> log2(STREAM_LEN) registered as the result
//   DONE  | result held on res_* until res_ready
module sc_convert_sched
  import sc_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int STREAM_LEN = SC_STREAM_LEN,
  parameter  int MAX_W      = SC_MAX_W,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*STREAM_LEN-1:0] stream_in,
  input  logic [N_REQ*MAX_W-1:0]      maxnum_in,
  output logic [N_REQ-1:0]            ack,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [MAX_W-1:0]            res_data,
  output logic [ID_W-1:0]             res_id,
  output logic                        busy
);

  sc_sched_state_t state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             res_valid_q, res_valid_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx, cand;
  logic             start, step, scale, last_bit;

  // Search starts one past the previous grant and wraps.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(last_q) + i) % N_REQ);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    res_id_d    = res_id_q;
    ack_d       = '0;
    res_valid_d = res_valid_q;
    start       = 1'b0;
    step        = 1'b0;
    scale       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          start            = 1'b1;
          ack_d[grant_idx] = 1'b1;
          last_d           = grant_idx;
          gid_d            = grant_idx;
          state_d          = COUNT;
        end
      end
      COUNT: begin
        step = 1'b1;
        if (last_bit) state_d = SCALE;
      end
      SCALE: begin
        scale       = 1'b1;
        res_id_d    = gid_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(N_REQ - 1);
      gid_q       <= '0;
      res_id_q    <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gid_q       <= gid_d;
      res_id_q    <= res_id_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
    end
  end

  sc_count_scale #(
    .STREAM_LEN (STREAM_LEN),
    .MAX_W      (MAX_W)
  ) u_count_scale (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .step_i     (step),
    .scale_i    (scale),
    .stream_i   (stream_in[grant_idx*STREAM_LEN +: STREAM_LEN]),
    .maxnum_i   (maxnum_in[grant_idx*MAX_W +: MAX_W]),
    .last_bit_o (last_bit),
    .result_o   (res_data)
  );

  assign ack       = ack_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sc_convert_sched.sv
// Self-checking bench for sc_convert_sched against a popcount/round-robin model.
module tb_sc_convert_sched;
  localparam int N = 4;
  localparam int L = 16;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*L-1:0] stream_in = '0;
  logic [N*W-1:0] maxnum_in = '0;
  logic [N-1:0]   ack;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sc_convert_sched #(.N_REQ(N), .STREAM_LEN(L), .MAX_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .stream_in(stream_in), .maxnum_in(maxnum_in),
    .ack(ack), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  // Reference: fraction of ones in the stream times full scale, truncated.
  function automatic int model_conv(input logic [L-1:0] s, input logic [W-1:0] m);
    return ($countones(s) * int'(m)) / L;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; res_ready = 1'b0; stream_in = '0; maxnum_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_ack(input int budget, output logic [N-1:0] a, output bit ok);
    ok = 1'b0; a = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (ack !== '0) begin a = ack; ok = 1'b1; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (res_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0;
    #3;
    checks++;
    if ({ack, res_valid, res_data, res_id, busy} !== '0) begin
      failures++; $display("FAIL reset_async got=%0h exp=0", {ack, res_valid, res_data, res_id, busy});
    end
    do_reset();
    checks++;
    if ({ack, res_valid, res_data, res_id, busy} !== '0) begin
      failures++; $display("FAIL reset_state got=%0h exp=0", {ack, res_valid, res_data, res_id, busy});
    end
    repeat (3) tick();
    checks++;
    if ({ack, busy} !== '0) begin
      failures++; $display("FAIL idle_no_req got=%0h exp=0", {ack, busy});
    end
  endtask

  task automatic test_full_scale();
    logic [N-1:0] a; bit ok;
    do_reset();
    stream_in[0 +: L] = 16'hFFFF; maxnum_in[0 +: W] = 8'd255; req = 4'b0001;
    wait_ack(5, a, ok);
    checks++;
    if (!ok || a !== 4'b0001) begin failures++; $display("FAIL fs_ack got=%b exp=0001 ok=%0d", a, ok); end
    req = '0;
    tick();
    checks++;
    if (ack !== '0 || busy !== 1'b1) begin failures++; $display("FAIL fs_ack_pulse ack=%b busy=%b exp ack=0 busy=1", ack, busy); end
    repeat (15) tick();
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL fs_early_valid got=%b exp=0", res_valid); end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'd255 || res_id !== 2'd0) begin
      failures++; $display("FAIL fs_result valid=%b data=%0d id=%0d exp 1/255/0", res_valid, res_data, res_id);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fs_accept valid=%b busy=%b exp 0/0", res_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] a; bit ok; int prev_cyc;
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_res[5] = '{100, 50, 0, 100, 100};
    do_reset();
    stream_in = {16'hAAAA, 16'h0000, 16'h000F, 16'h00FF};
    maxnum_in = {8'd200, 8'd200, 8'd200, 8'd200};
    req = 4'b1111; res_ready = 1'b1; prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, a, ok);
      checks++;
      if (!ok || a !== (4'b0001 << exp_id[k])) begin
        failures++; $display("FAIL rr_grant[%0d] got=%b exp_id=%0d ok=%0d", k, a, exp_id[k], ok);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev_cyc !== L + 3) begin failures++; $display("FAIL rr_period[%0d] got=%0d exp=%0d", k, cyc - prev_cyc, L + 3); end
      end
      prev_cyc = cyc;
      wait_valid(40, ok);
      checks++;
      if (!ok || res_data !== W'(exp_res[k]) || res_id !== 2'(exp_id[k])) begin
        failures++; $display("FAIL rr_result[%0d] data=%0d id=%0d exp %0d/%0d ok=%0d", k, res_data, res_id, exp_res[k], exp_id[k], ok);
      end
      if (k == 4) req = '0;
    end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] a; bit ok;
    do_reset();
    stream_in[0 +: L] = 16'h0007; maxnum_in[0 +: W] = 8'd100; req = 4'b0001;
    wait_ack(5, a, ok);
    req = 4'b0010;
    wait_valid(40, ok);
    checks++;
    if (!ok || res_data !== 8'd18 || res_id !== 2'd0) begin
      failures++; $display("FAIL bp_result data=%0d id=%0d exp 18/0 ok=%0d", res_data, res_id, ok);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({res_valid, res_data, busy, ack} !== {1'b1, 8'd18, 1'b1, 4'b0000}) begin
        failures++; $display("FAIL bp_hold[%0d] valid=%b data=%0d busy=%b ack=%b exp 1/18/1/0000", i, res_valid, res_data, busy, ack);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || ack !== '0) begin failures++; $display("FAIL bp_accept valid=%b ack=%b exp 0/0000", res_valid, ack); end
    tick();
    checks++;
    if (ack !== 4'b0010) begin failures++; $display("FAIL bp_next_grant got=%b exp=0010", ack); end
    req = '0; res_ready = 1'b1;
    wait_valid(40, ok);
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_latched_operands();
    logic [N-1:0] a; bit ok;
    do_reset();
    stream_in[0 +: L] = 16'hFFFF; maxnum_in[0 +: W] = 8'd0; req = 4'b0001;
    wait_ack(5, a, ok);
    req = '0;
    tick();
    stream_in[0 +: L] = 16'($urandom); maxnum_in[0 +: W] = 8'd255;
    wait_valid(40, ok);
    checks++;
    if (!ok || res_data !== 8'd0) begin failures++; $display("FAIL maxnum_zero got=%0d exp=0 ok=%0d", res_data, ok); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    stream_in[0 +: L] = 16'h1234; maxnum_in[0 +: W] = 8'd250; req = 4'b0001;
    wait_ack(5, a, ok);
    req = '0;
    repeat (5) tick();
    stream_in[0 +: L] = 16'hFFFF; maxnum_in[0 +: W] = 8'd255;
    wait_valid(40, ok);
    checks++;
    if (!ok || res_data !== 8'd78) begin failures++; $display("FAIL latch_operands got=%0d exp=78 ok=%0d", res_data, ok); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] a; bit ok;
    do_reset();
    stream_in[0 +: L] = 16'hFFFF; maxnum_in[0 +: W] = 8'd255; req = 4'b0001; res_ready = 1'b1;
    wait_ack(5, a, ok);
    req = '0;
    wait_valid(40, ok);
    tick();
    res_ready = 1'b0;
    stream_in[L +: L] = 16'hFFFF; maxnum_in[W +: W] = 8'd255; req = 4'b0010;
    wait_ack(5, a, ok);
    req = '0;
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, res_valid, res_data, res_id, busy} !== '0) begin
      failures++; $display("FAIL midflight_reset got=%0h exp=0", {ack, res_valid, res_data, res_id, busy});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    stream_in[0 +: L] = 16'h00FF; maxnum_in[0 +: W] = 8'd160; req = 4'b0101;
    wait_ack(5, a, ok);
    checks++;
    if (!ok || a !== 4'b0001) begin failures++; $display("FAIL post_reset_grant got=%b exp=0001 ok=%0d", a, ok); end
    req = '0; res_ready = 1'b1;
    wait_valid(40, ok);
    checks++;
    if (!ok || res_data !== 8'd80 || res_id !== 2'd0) begin
      failures++; $display("FAIL post_reset_result data=%0d id=%0d exp 80/0 ok=%0d", res_data, res_id, ok);
    end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_drop_request();
    logic [N-1:0] a; bit ok; int seen1;
    do_reset();
    stream_in[0 +: L] = 16'hFFFF; maxnum_in[0 +: W] = 8'd16; req = 4'b0001;
    wait_ack(5, a, ok);
    req = 4'b0010; seen1 = 0;
    repeat (3) begin tick(); if (ack[1] === 1'b1) seen1++; end
    req = 4'b0000;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (ack[1] === 1'b1) seen1++;
      if (res_valid === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || res_data !== 8'd16) begin failures++; $display("FAIL drop_first_result got=%0d exp=16 ok=%0d", res_data, ok); end
    req = 4'b1000; res_ready = 1'b1;
    wait_ack(5, a, ok);
    checks++;
    if (!ok || a !== 4'b1000) begin failures++; $display("FAIL drop_next_grant got=%b exp=1000 ok=%0d", a, ok); end
    checks++;
    if (seen1 !== 0) begin failures++; $display("FAIL dropped_req_acked got=%0d exp=0", seen1); end
    req = '0;
    wait_valid(40, ok);
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] a, r; bit ok; int last, exp_id, exp_val;
    logic [L-1:0] s; logic [W-1:0] m;
    do_reset();
    last = N - 1;
    for (int t = 0; t < 25; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        s = (t % 5 == 0) ? '1 : (t % 7 == 0) ? '0 : L'($urandom);
        stream_in[i*L +: L] = s;
        maxnum_in[i*W +: W] = W'($urandom);
      end
      req = r;
      exp_id = -1;
      for (int k = 1; k <= N; k++) begin
        if (exp_id < 0 && r[(last + k) % N]) exp_id = (last + k) % N;
      end
      s = stream_in[exp_id*L +: L];
      m = maxnum_in[exp_id*W +: W];
      exp_val = model_conv(s, m);
      last = exp_id;
      wait_ack(5, a, ok);
      checks++;
      if (!ok || a !== (4'b0001 << exp_id)) begin
        failures++; $display("FAIL rand_grant[%0d] got=%b exp_id=%0d ok=%0d", t, a, exp_id, ok);
      end
      req = N'($urandom);
      stream_in = {$urandom, $urandom};
      maxnum_in = $urandom;
      wait_valid(40, ok);
      checks++;
      if (!ok || res_data !== W'(exp_val) || res_id !== 2'(exp_id)) begin
        failures++; $display("FAIL rand_result[%0d] data=%0d id=%0d exp %0d/%0d ok=%0d", t, res_data, res_id, exp_val, exp_id, ok);
      end
      repeat ($urandom_range(0, 3)) tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_round_robin();
    test_backpressure();
    test_latched_operands();
    test_reset_midflight();
    test_drop_request();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
